// File: rtl/fifo_flagged.sv
// Synchronous FIFO with fill count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow, synchronous flush and selectable FWFT/registered output.
module fifo_flagged #(
  parameter int FIFO_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4,
  parameter int FWFT         = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          pop,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  empty_w;
  logic                  full_w;
  logic                  push_ok;
  logic                  pop_ok;

  // Extra wrap bit on each pointer lets all FIFO_DEPTH entries be used.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_ok  = pop && !empty_w;
  assign push_ok = push && (!full_w || pop_ok);

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + PW'(push_ok) - PW'(pop_ok);
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && empty_w)   underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out       = mem[rd_ptr[AW-1:0]];
    assign data_out_valid = !empty_w;
  end else begin : g_reg
    // Registered read: one-cycle valid pulse; data holds between reads and across flush.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_out       <= '0;
        data_out_valid <= 1'b0;
      end else if (flush) begin
        data_out_valid <= 1'b0;
      end else if (pop_ok) begin
        data_out       <= mem[rd_ptr[AW-1:0]];
        data_out_valid <= 1'b1;
      end else begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: an FWFT and a registered-output instance share one stimulus
// and are compared every cycle against a queue-based reference model.
module tb_fifo_flagged;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [W-1:0] dout   [2];
  logic         dv     [2];
  logic         full_o [2];
  logic         empty_o[2];
  logic         af_o   [2];
  logic         ae_o   [2];
  logic [4:0]   cnt_o  [2];
  logic         ovf_o  [2];
  logic         unf_o  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_ovf, m_unf;
  logic [W-1:0] m_d0;
  logic         m_v0;

  always #5 clk = ~clk;

  fifo_flagged #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(dout[0]), .data_out_valid(dv[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(cnt_o[0]),
    .overflow(ovf_o[0]), .underflow(unf_o[0]));

  fifo_flagged #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE), .FWFT(0)) u_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(dout[1]), .data_out_valid(dv[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(cnt_o[1]),
    .overflow(ovf_o[1]), .underflow(unf_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[%0d]", i), 32'(cnt_o[i]), 32'(n));
      chk($sformatf("empty[%0d]", i), 32'(empty_o[i]), 32'(n == 0));
      chk($sformatf("full[%0d]", i), 32'(full_o[i]), 32'(n == D));
      chk($sformatf("almost_full[%0d]", i), 32'(af_o[i]), 32'(n >= AF));
      chk($sformatf("almost_empty[%0d]", i), 32'(ae_o[i]), 32'(n <= AE));
      chk($sformatf("overflow[%0d]", i), 32'(ovf_o[i]), 32'(m_ovf));
      chk($sformatf("underflow[%0d]", i), 32'(unf_o[i]), 32'(m_unf));
    end
    chk("valid_fwft", 32'(dv[0]), 32'(n != 0));
    if (n != 0) chk("data_fwft", 32'(dout[0]), 32'(q[0]));
    chk("valid_reg", 32'(dv[1]), 32'(m_v0));
    chk("data_reg", 32'(dout[1]), 32'(m_d0));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_d0  = '0;
    m_v0  = 1'b0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic p, input logic [W-1:0] d, input logic r, input logic f);
    logic take_pop, take_push;
    push = p; data_in = d; pop = r; flush = f;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    take_pop  = r && (q.size() > 0);
    take_push = p && ((q.size() < D) || take_pop);
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_v0  = 1'b0;
    end else begin
      if (p && !take_push) m_ovf = 1'b1;
      if (r && q.size() == 0) m_unf = 1'b1;
      if (take_pop) begin
        m_d0 = q.pop_front();
        m_v0 = 1'b1;
      end else begin
        m_v0 = 1'b0;
      end
      if (take_push) q.push_back(d);
    end
    check_all();
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to full in order, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Overflow: push to a full FIFO is dropped and the flag sticks.
    for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);

    // Full with simultaneous push and pop: both accepted, 0x55 read last.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Empty with simultaneous push and pop: underflow, word appears next cycle.
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back registered reads.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Flush at count 9 with overflow set; same-cycle push ignored.
    for (int i = 0; i < 17; i++) step(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Random push/pop across pointer wraps.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 99) < 60), W'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 99) < 45), W'($urandom), 1'($urandom_range(0, 99) < 55), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
